// File: rtl/sine_fixed.sv
// Multi-cycle Q16.16 sine of an integer angle in degrees, via a 91-entry quarter-wave table.
// Build option: define SINE_NEG_ANGLE_EN to read values 360..511 as -152..-1 degrees.
module sine_fixed (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start,
  input  logic [8:0]  value,
  output logic        done,
  output logic [31:0] amp_out
);

  typedef enum logic [1:0] {IDLE, FOLD, LOOKUP, OUT} state_t;

  state_t      state;
  logic [8:0]  ang;
  logic [6:0]  k;
  logic        neg;
  logic [16:0] mag;

  logic [8:0]  a;
  logic [6:0]  k_fold;
  logic        neg_fold;

  // round(65536 * sin(idx degrees)) for idx = 0..90
  function automatic logic [16:0] sin_lut(input logic [6:0] idx);
    logic [16:0] v;
    // NOTE: a default arm covers idx 91..127, so the case never leaves v unassigned.
    case (idx)
      7'd0:  v = 17'd0;     7'd1:  v = 17'd1144;  7'd2:  v = 17'd2287;  7'd3:  v = 17'd3430;
      7'd4:  v = 17'd4572;  7'd5:  v = 17'd5712;  7'd6:  v = 17'd6850;  7'd7:  v = 17'd7987;
      7'd8:  v = 17'd9121;  7'd9:  v = 17'd10252; 7'd10: v = 17'd11380; 7'd11: v = 17'd12505;
      7'd12: v = 17'd13626; 7'd13: v = 17'd14742; 7'd14: v = 17'd15855; 7'd15: v = 17'd16962;
      7'd16: v = 17'd18064; 7'd17: v = 17'd19161; 7'd18: v = 17'd20252; 7'd19: v = 17'd21336;
      7'd20: v = 17'd22415; 7'd21: v = 17'd23486; 7'd22: v = 17'd24550; 7'd23: v = 17'd25607;
      7'd24: v = 17'd26656; 7'd25: v = 17'd27697; 7'd26: v = 17'd28729; 7'd27: v = 17'd29753;
      7'd28: v = 17'd30767; 7'd29: v = 17'd31772; 7'd30: v = 17'd32768; 7'd31: v = 17'd33754;
      7'd32: v = 17'd34729; 7'd33: v = 17'd35693; 7'd34: v = 17'd36647; 7'd35: v = 17'd37590;
      7'd36: v = 17'd38521; 7'd37: v = 17'd39441; 7'd38: v = 17'd40348; 7'd39: v = 17'd41243;
      7'd40: v = 17'd42126; 7'd41: v = 17'd42995; 7'd42: v = 17'd43852; 7'd43: v = 17'd44695;
      7'd44: v = 17'd45525; 7'd45: v = 17'd46341; 7'd46: v = 17'd47143; 7'd47: v = 17'd47930;
      7'd48: v = 17'd48703; 7'd49: v = 17'd49461; 7'd50: v = 17'd50203; 7'd51: v = 17'd50931;
      7'd52: v = 17'd51643; 7'd53: v = 17'd52339; 7'd54: v = 17'd53020; 7'd55: v = 17'd53684;
      7'd56: v = 17'd54332; 7'd57: v = 17'd54963; 7'd58: v = 17'd55578; 7'd59: v = 17'd56175;
      7'd60: v = 17'd56756; 7'd61: v = 17'd57319; 7'd62: v = 17'd57865; 7'd63: v = 17'd58393;
      7'd64: v = 17'd58903; 7'd65: v = 17'd59396; 7'd66: v = 17'd59870; 7'd67: v = 17'd60326;
      7'd68: v = 17'd60764; 7'd69: v = 17'd61183; 7'd70: v = 17'd61584; 7'd71: v = 17'd61966;
      7'd72: v = 17'd62328; 7'd73: v = 17'd62672; 7'd74: v = 17'd62997; 7'd75: v = 17'd63303;
      7'd76: v = 17'd63589; 7'd77: v = 17'd63856; 7'd78: v = 17'd64104; 7'd79: v = 17'd64332;
      7'd80: v = 17'd64540; 7'd81: v = 17'd64729; 7'd82: v = 17'd64898; 7'd83: v = 17'd65048;
      7'd84: v = 17'd65177; 7'd85: v = 17'd65287; 7'd86: v = 17'd65376; 7'd87: v = 17'd65446;
      7'd88: v = 17'd65496; 7'd89: v = 17'd65526; 7'd90: v = 17'd65536;
      default: v = 17'd0;
    endcase
    return v;
  endfunction

  // Bring the latched angle into 0..359; the negative build maps x-512 to its mod-360 twin.
  always_comb begin
    a = ang;
    if (ang >= 9'd360) begin
`ifdef SINE_NEG_ANGLE_EN
      a = ang - 9'd152;
`else
      a = ang - 9'd360;
`endif
    end
  end

  always_comb begin
    k_fold   = 7'(a);
    neg_fold = 1'b0;
    if (a <= 9'd90) begin
      k_fold = 7'(a);
    end else if (a <= 9'd180) begin
      k_fold = 7'(9'd180 - a);
    end else if (a <= 9'd270) begin
      k_fold   = 7'(a - 9'd180);
      neg_fold = 1'b1;
    end else begin
      k_fold   = 7'(9'd360 - a);
      neg_fold = 1'b1;
    end
  end

  // NOTE: every register here uses <= so each stage sees the previous stage's old value.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      done    <= 1'b0;
      amp_out <= 32'd0;
      ang     <= 9'd0;
      k       <= 7'd0;
      neg     <= 1'b0;
      mag     <= 17'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ang   <= value;
            state <= FOLD;
          end
        end
        FOLD: begin
          k     <= k_fold;
          neg   <= neg_fold;
          state <= LOOKUP;
        end
        LOOKUP: begin
          mag   <= sin_lut(k);
          state <= OUT;
        end
        OUT: begin
          // Two's-complement negation of zero is zero, so 180 degrees never yields -0.
          amp_out <= neg ? -{15'd0, mag} : {15'd0, mag};
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_fixed.sv
// Scoreboard bench for sine_fixed: the driver queues expected results, a monitor checks each done.
// Honours SINE_NEG_ANGLE_EN the same way as the design build.
module tb_sine_fixed;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start  = 1'b0;
  logic [8:0]  value  = 9'd0;
  logic        done;
  logic [31:0] amp_out;

  sine_fixed dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start   (start),
    .value   (value),
    .done    (done),
    .amp_out (amp_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int v;
    int exp_amp;
    int sample_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   next_idle = 0;
  int   last_amp  = 0;
  bit   prev_done = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: sine of the angle in degrees, rounded half away from zero.
  function automatic int ref_sin(input int v);
    real deg;
    real r;
    deg = real'(v);
    if (v >= 360) begin
`ifdef SINE_NEG_ANGLE_EN
      deg = real'(v - 512);
`else
      deg = real'(v - 360);
`endif
    end
    r = 65536.0 * $sin(deg * 3.14159265358979323846 / 180.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Hand-derived expectations for the directed angles.
  function automatic int dir_exp(input int v);
    case (v)
      90:  return 65536;
      30:  return 32768;
      210: return -32768;
      270: return -65536;
      0:   return 0;
      135: return 46341;
      315: return -46341;
      180: return 0;
      60:  return 56756;
      45:  return 46341;
      359: return -1144;
      91:  return 65526;
      181: return -1144;
      271: return -65526;
`ifdef SINE_NEG_ANGLE_EN
      450: return -57865;
      360: return -30767;
      511: return -1144;
`else
      450: return 65536;
      360: return 0;
      511: return 31772;
`endif
      default: return 0;
    endcase
  endfunction

  // One cycle of stimulus; the DUT is idle and samples at edge cyc+1 when it has finished.
  task automatic drive(input bit s, input int v, input int exp_amp, output bit sampled);
    exp_t e;
    @(negedge clk_in);
    start   = s;
    value   = 9'(v);
    sampled = 1'b0;
    if (s && rst_in && (cyc + 1 >= next_idle)) begin
      e.v          = v;
      e.exp_amp    = exp_amp;
      e.sample_cyc = cyc + 1;
      sb.push_back(e);
      next_idle = cyc + 1 + 4;
      sampled   = 1'b1;
    end
  endtask

  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (rst_in) begin
      if (done) begin
        check("done_back_to_back", int'(prev_done), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("amp v=%0d", e.v), int'($signed(amp_out)), e.exp_amp);
          check($sformatf("latency v=%0d", e.v), cyc - e.sample_cyc, 3);
          last_amp = e.exp_amp;
        end
      end else begin
        check("amp_hold", int'($signed(amp_out)), last_amp);
        if (sb.size() > 0 && cyc > sb[0].sample_cyc + 3) begin
          check($sformatf("missing_done v=%0d", sb[0].v), int'(done), 1);
          void'(sb.pop_front());
        end
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dir_v[] = '{90, 30, 210, 270, 0, 135, 315, 180, 450, 60, 45, 359, 360, 511, 91, 181, 271};
    bit  smp;
    int  tries;
    int  v;
    bit  s;

    repeat (3) @(negedge clk_in);
    #1;
    check("reset done", int'(done), 0);
    check("reset amp", int'($signed(amp_out)), 0);
    rst_in    = 1'b1;
    next_idle = cyc + 1;

    foreach (dir_v[i]) repeat (4) drive(1'b1, dir_v[i], dir_exp(dir_v[i]), smp);

    // value changes while a result is in flight
    drive(1'b1, 30, 32768, smp);
    repeat (3) drive(1'b1, 60, 56756, smp);
    repeat (4) drive(1'b1, 60, 56756, smp);

    // idle gap: outputs must hold, no done
    repeat (10) drive(1'b0, 270, 0, smp);

    // abort in LOOKUP via asynchronous reset
    tries = 0;
    smp   = 1'b0;
    while (!smp && tries < 8) begin
      drive(1'b1, 90, 65536, smp);
      tries++;
    end
    check("reset test sample taken", int'(smp), 1);
    drive(1'b0, 90, 65536, smp);
    @(negedge clk_in);
    rst_in = 1'b0;
    sb.delete();
    last_amp = 0;
    #1;
    check("mid-op reset done", int'(done), 0);
    check("mid-op reset amp", int'($signed(amp_out)), 0);
    repeat (3) @(negedge clk_in);
    check("held reset done", int'(done), 0);
    check("held reset amp", int'($signed(amp_out)), 0);
    rst_in    = 1'b1;
    next_idle = cyc + 1;
    repeat (8) drive(1'b0, 135, 0, smp);
    repeat (4) drive(1'b1, 135, 46341, smp);

    // randomized angles, mostly with start held, value changing every cycle
    repeat (600) begin
      s = ($urandom_range(0, 7) != 0);
      v = int'($urandom_range(0, 511));
      drive(s, v, ref_sin(v), smp);
    end

    repeat (8) drive(1'b0, 0, 0, smp);
    check("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_fixed.md
# sine_fixed

Combinational-free, multi-cycle sine evaluator: it converts a 9-bit integer angle in degrees to a signed Q16.16 sine amplitude using a quarter-wave lookup table with quadrant folding. It serves as the trig primitive for the orientation/view-vector logic, which instantiates two copies with `start` tied high and steps through angles by waiting on `done`. The module name is `sine_fixed`.

## Interface
- No parameters.
- `clk_in`  in  1  system clock; all state updates on its rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE; may be held high permanently.
- `value`  in  9  angle in degrees, unsigned integer 0–511; sampled with `start`.
- `done`  out  1  one-cycle pulse; `amp_out` holds a new result from this cycle on.
- `amp_out`  out  32  signed Q16.16 sine of the latched angle, range −65536..+65536.

## Operation
- States: IDLE → FOLD → LOOKUP → OUT → IDLE.
- IDLE: if `start`=1, latch `value` into internal `ang` and go to FOLD; else stay.
- FOLD: normalise to a ∈ 0..359.
  - `value` 0..359 is used as is.
  - `value` 360..511 is handled per Configuration.
  - Quadrant and index k (0..90) are derived as follows:
    - a ≤ 90: k = a, positive.
    - 91..180: k = 180 − a, positive.
    - 181..270: k = a − 180, negative.
    - 271..359: k = 360 − a, negative.
- LOOKUP: register T[k], where T is a 91-entry constant table with T[k] = round(65536·sin(k°)).
  - Anchor entries: T[0]=0, T[30]=32768, T[45]=46341, T[60]=56756, T[90]=65536.
- OUT: `amp_out` ← negative ? −T[k] : T[k], sign-extended to 32 bits; `done` ← 1 for this one cycle; return to IDLE.
- `amp_out` holds its last result between completions. Changes on `value` after latching do not affect the result in flight.
- No overflow is possible: |amp_out| ≤ 65536.

## Timing
- Reset (`rst_in`=0, asynchronous): state=IDLE, `done`=0, `amp_out`=0, `ang`=0.
  - Reset asserted mid-computation aborts the operation; no `done` is produced.
  - After release, the first `start` is sampled on the first rising edge.
- Latency: `start` sampled high at edge N → `amp_out`/`done` registered at edge N+3. `done` is high for exactly one cycle.
- `start` held high: a new sample is taken at edge N+4, giving one result every 4 cycles. `done` is never high on two consecutive cycles.
- `start`=0 in IDLE: outputs hold and `done`=0.
- `start` is ignored outside IDLE; there is no queuing.
- Callers that change `value` must ignore the first `done` after the change if it belongs to an earlier sample. Waiting for two `done` pulses guarantees a fresh result.

## Configuration
- `SINE_NEG_ANGLE_EN` defined: `value` 360..511 is treated as value − 512 (−152..−1°), i.e. 9-bit two's-complement wrap of a subtraction like 90 − x. It is folded as a = value − 152, using the mod-360 equivalent, so sin(−θ) = −sin(θ).
- Not defined: `value` 360..511 is reduced as value − 360 (0..151°).
- Latency and interface are identical in both builds.

## Test plan
- Reset, then `start`=1, `value`=90 → `done` pulse 3 edges after the first sample, `amp_out`=65536.
- `value`=30 → `amp_out`=32768; `value`=210 → −32768; `value`=270 → −65536; `value`=0 → 0.
- `value`=135 → 46341; `value`=315 → −46341; `value`=180 → 0 (no −0 artifact).
- `value`=450:
  - with `SINE_NEG_ANGLE_EN` (−62°) → −57865.
  - without the macro (90°) → 65536.
- `start` held high with `value` changed mid-operation → the in-flight result matches the old angle, the next one matches the new angle, and `done` pulses exactly every 4 cycles.
- Assert `rst_in`=0 in LOOKUP → `done`=0 and `amp_out`=0 immediately, and no pulse occurs until a fresh `start` after release.
